// File: rtl/hue_sequencer_pkg.sv
// Shared types for the RGB fade path: colour-wheel sectors, per-channel duty modes,
// and the sector-to-mode table.
package hue_sequencer_pkg;

  localparam int HUE_MAX    = 359;
  localparam int SECTOR_DEG = 60;

  typedef enum logic [2:0] {
    X0TO60, X60TO120, X120TO180, X180TO240, X240TO300, X300TO360
  } sector_t;

  typedef enum logic [1:0] {
    INCREMENTING, DECREMENTING, HIGH_HOLD, LOW_HOLD
  } channel_mode_t;

  typedef enum logic [1:0] {CH_R, CH_G, CH_B} channel_t;

  function automatic sector_t next_sector(sector_t s);
    return (s == X300TO360) ? X0TO60 : sector_t'(s + 3'd1);
  endfunction

  function automatic channel_mode_t sector_mode(sector_t s, channel_t ch);
    channel_mode_t m;
    m = LOW_HOLD;
    case (s)
      X0TO60:    m = (ch == CH_R) ? HIGH_HOLD    : (ch == CH_G) ? INCREMENTING : LOW_HOLD;
      X60TO120:  m = (ch == CH_R) ? DECREMENTING : (ch == CH_G) ? HIGH_HOLD    : LOW_HOLD;
      X120TO180: m = (ch == CH_R) ? LOW_HOLD     : (ch == CH_G) ? HIGH_HOLD    : INCREMENTING;
      X180TO240: m = (ch == CH_R) ? LOW_HOLD     : (ch == CH_G) ? DECREMENTING : HIGH_HOLD;
      X240TO300: m = (ch == CH_R) ? INCREMENTING : (ch == CH_G) ? LOW_HOLD     : HIGH_HOLD;
      X300TO360: m = (ch == CH_R) ? HIGH_HOLD    : (ch == CH_G) ? LOW_HOLD     : DECREMENTING;
      default:   m = LOW_HOLD;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/hue_sequencer_if.sv
// Control and result bundle between the hue sequencer and the PWM stages that consume its duties.
interface hue_sequencer_if #(parameter int DW = 11);
  logic          enable;
  logic [DW-1:0] r_duty;
  logic [DW-1:0] g_duty;
  logic [DW-1:0] b_duty;
  logic [8:0]    hue;
  logic [2:0]    sector;
  logic          period_strobe;

  modport master (input enable, output r_duty, g_duty, b_duty, hue, sector, period_strobe);
  modport slave  (output enable, input r_duty, g_duty, b_duty, hue, sector, period_strobe);
endinterface

// File: rtl/hue_sequencer_period_timer.sv
// Free-running PWM period counter with a registered strobe on the last clk of each period.
module period_timer #(
  parameter int PWM_INTERVAL = 1200
) (
  input  logic clk,
  input  logic reset,
  output logic period_strobe
);
  localparam int CW = $clog2(PWM_INTERVAL);
  localparam logic [CW-1:0] LAST = CW'(PWM_INTERVAL - 1);

  logic [CW-1:0] period_cnt_q, period_cnt_d;
  logic          period_strobe_q, period_strobe_d;

  always_comb begin
    period_cnt_d    = (period_cnt_q == LAST) ? '0 : period_cnt_q + 1'b1;
    // Strobe is decoded from the next count so it is high while the count sits at LAST.
    period_strobe_d = (period_cnt_d == LAST);
  end

  // NOTE: state updates use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      period_cnt_q    <= '0;
      period_strobe_q <= 1'b0;
    end else begin
      period_cnt_q    <= period_cnt_d;
      period_strobe_q <= period_strobe_d;
    end
  end

  assign period_strobe = period_strobe_q;
endmodule

// File: rtl/hue_sequencer.sv
// Sweeps hue around the colour wheel and emits per-channel PWM duties, updated only on period boundaries.
module hue_sequencer
  import hue_sequencer_pkg::*;
#(
  parameter int PWM_INTERVAL    = 1200,
  parameter int PERIODS_PER_DEG = 28
) (
  input  logic            clk,
  input  logic            reset,
  hue_sequencer_if.master bus
);
  localparam int DW   = $clog2(PWM_INTERVAL + 1);
  localparam int STEP = PWM_INTERVAL / SECTOR_DEG;
  localparam int DCW  = (PERIODS_PER_DEG > 1) ? $clog2(PERIODS_PER_DEG) : 1;
  localparam logic [DW-1:0] FULL = DW'(PWM_INTERVAL);

  logic          strobe;
  logic          advance;
  logic [DCW-1:0] deg_cnt_q, deg_cnt_d;
  logic [8:0]    hue_q, hue_d;
  logic [5:0]    offset_q, offset_d;
  sector_t       sector_q, sector_d;
  logic [DW-1:0] ramp_q, ramp_d;
  logic [DW-1:0] r_duty_q, r_duty_d;
  logic [DW-1:0] g_duty_q, g_duty_d;
  logic [DW-1:0] b_duty_q, b_duty_d;

  period_timer #(.PWM_INTERVAL(PWM_INTERVAL)) u_timer (
    .clk          (clk),
    .reset        (reset),
    .period_strobe(strobe)
  );

  function automatic logic [DW-1:0] duty_of(channel_mode_t m, logic [DW-1:0] r);
    case (m)
      HIGH_HOLD:    return FULL;
      INCREMENTING: return r;
      DECREMENTING: return FULL - r;
      default:      return '0;
    endcase
  endfunction

  always_comb begin
    // NOTE: every variable gets a hold default first, so no path through this block infers a latch.
    advance   = 1'b0;
    deg_cnt_d = deg_cnt_q;
    hue_d     = hue_q;
    offset_d  = offset_q;
    sector_d  = sector_q;
    ramp_d    = ramp_q;
    r_duty_d  = r_duty_q;
    g_duty_d  = g_duty_q;
    b_duty_d  = b_duty_q;

    if (strobe && bus.enable) begin
      if (deg_cnt_q == DCW'(PERIODS_PER_DEG - 1)) begin
        deg_cnt_d = '0;
        advance   = 1'b1;
      end else begin
        deg_cnt_d = deg_cnt_q + 1'b1;
      end
    end

    if (advance) begin
      hue_d = (hue_q == 9'(HUE_MAX)) ? '0 : hue_q + 1'b1;
      if (offset_q == 6'(SECTOR_DEG - 1)) begin
        offset_d = '0;
        sector_d = next_sector(sector_q);
        ramp_d   = '0;
      end else begin
        offset_d = offset_q + 1'b1;
        ramp_d   = ramp_q + DW'(STEP);
      end
      // Duties follow the post-advance sector/ramp so they land on the same edge as hue.
      r_duty_d = duty_of(sector_mode(sector_d, CH_R), ramp_d);
      g_duty_d = duty_of(sector_mode(sector_d, CH_G), ramp_d);
      b_duty_d = duty_of(sector_mode(sector_d, CH_B), ramp_d);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      deg_cnt_q <= '0;
      hue_q     <= '0;
      offset_q  <= '0;
      sector_q  <= X0TO60;
      ramp_q    <= '0;
      r_duty_q  <= FULL;
      g_duty_q  <= '0;
      b_duty_q  <= '0;
    end else begin
      deg_cnt_q <= deg_cnt_d;
      hue_q     <= hue_d;
      offset_q  <= offset_d;
      sector_q  <= sector_d;
      ramp_q    <= ramp_d;
      r_duty_q  <= r_duty_d;
      g_duty_q  <= g_duty_d;
      b_duty_q  <= b_duty_d;
    end
  end

  assign bus.hue           = hue_q;
  assign bus.sector        = sector_q;
  assign bus.r_duty        = r_duty_q;
  assign bus.g_duty        = g_duty_q;
  assign bus.b_duty        = b_duty_q;
  assign bus.period_strobe = strobe;
endmodule
